// File: rtl/cfr_ipif_pkg.sv
// Shared types and constants for the CFR IPIF initiator.
// Timeout support is selected by the CFR_IPIF_TIMEOUT_EN macro in the RTL that imports this.
package cfr_ipif_pkg;

    localparam int unsigned CFR_IPIF_ADDR_WIDTH = 10;
    localparam int unsigned CFR_IPIF_DATA_WIDTH = 32;

    // Filler pattern that responders drive on rd_data when not acknowledging.
    localparam logic [31:0] CFR_IPIF_BAD_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StRsp
    } cfr_ipif_state_t;

    typedef struct packed {
        logic                           write;
        logic [CFR_IPIF_ADDR_WIDTH-1:0] addr;
        logic [CFR_IPIF_DATA_WIDTH-1:0] wdata;
    } cfr_ipif_cmd_t;

endpackage

// File: rtl/cfr_ipif_timeout.sv
// Saturating ack-wait counter; only instantiated when CFR_IPIF_TIMEOUT_EN is defined.
module cfr_ipif_timeout
    import cfr_ipif_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (run && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The TIMEOUT-th wait cycle is the last one; leaving on it means rsp follows TIMEOUT waits.
    assign expired = run && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/cfr_ipif_initiator.sv
// CFR IPIF initiator: valid/ready command stream to single-cycle wr_req/rd_req with ack wait.
// Ack timeout (rsp_error) is built only when CFR_IPIF_TIMEOUT_EN is defined.
module cfr_ipif_initiator
    import cfr_ipif_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CFR_IPIF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = CFR_IPIF_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  wr_req,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_req,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ack
);

    cfr_ipif_state_t state_q, state_d;

    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;
    logic                  cmd_ready_q, wr_req_q, rd_req_q, rsp_valid_q;
    logic                  accept, ack_hit, expired;

    assign accept  = cmd_valid && cmd_ready_q;
    assign ack_hit = write_q ? wr_ack : rd_ack;

`ifdef CFR_IPIF_TIMEOUT_EN
    cfr_ipif_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (state_q == StReq),
        .run    (state_q == StWait),
        .expired(expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expired        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StReq;
                    write_d = cmd_write;
                    if (cmd_write) begin
                        wr_addr_d = cmd_addr;
                        wr_data_d = cmd_wdata;
                    end else begin
                        rd_addr_d = cmd_addr;
                    end
                end
            end
            StReq: state_d = StWait;
            StWait: begin
                // A matching ack in the expiry cycle still counts as a good response.
                if (ack_hit) begin
                    state_d     = StRsp;
                    rsp_rdata_d = write_q ? '0 : rd_data;
                    rsp_error_d = 1'b0;
                end else if (expired) begin
                    state_d     = StRsp;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs are registered from the next state so they are all 0 under reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            cmd_ready_q <= (state_d == StIdle);
            wr_req_q    <= (state_d == StReq) && write_d;
            rd_req_q    <= (state_d == StReq) && !write_d;
            rsp_valid_q <= (state_d == StRsp);
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign wr_req    = wr_req_q;
    assign rd_addr   = rd_addr_q;
    assign rd_req    = rd_req_q;

endmodule

// File: tb/tb_cfr_ipif_initiator.sv
// Scoreboard bench for cfr_ipif_initiator: random commands, modelled responder, queued expectations.
// Timeout cases are exercised when CFR_IPIF_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_cfr_ipif_initiator;
    import cfr_ipif_pkg::*;

    localparam int unsigned AW  = CFR_IPIF_ADDR_WIDTH;
    localparam int unsigned DW  = CFR_IPIF_DATA_WIDTH;
    localparam int unsigned TMO = 4;
`ifdef CFR_IPIF_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_write, rsp_error;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          wr_req, wr_ack, rd_req, rd_ack;
    logic [DW-1:0] wr_data, rd_data;

    always #5 clk = ~clk;

    cfr_ipif_initiator #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error),
        .wr_addr  (wr_addr),
        .wr_req   (wr_req),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .rd_addr  (rd_addr),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_ack   (rd_ack)
    );

    typedef struct {
        logic          write;
        logic [DW-1:0] rdata;
        logic          error;
        int            lat;
    } rsp_exp_t;

    typedef struct {
        int dly;
        int stray_at;
    } ack_plan_t;

    cfr_ipif_cmd_t req_q[$];
    rsp_exp_t      rsp_q[$];
    ack_plan_t     plan_q[$];
    logic [DW-1:0] ref_mem  [1024];
    logic [DW-1:0] resp_mem [1024];

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          rsp_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outcome derives from the command, the memory image and the ack delay.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int dly, input int stray_at);
        rsp_exp_t      r;
        cfr_ipif_cmd_t c;
        ack_plan_t     p;
        int            n;
        logic          err;
        err     = TMO_EN && (dly >= int'(TMO));
        c.write = wr;
        c.addr  = a;
        c.wdata = d;
        r.write = wr;
        r.error = err;
        r.rdata = (wr || err) ? '0 : ref_mem[a];
        r.lat   = err ? int'(TMO) + 1 : dly + 2;
        if (wr) ref_mem[a] = d;
        p.dly      = dly;
        p.stray_at = stray_at;
        req_q.push_back(c);
        rsp_q.push_back(r);
        plan_q.push_back(p);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            errors++;
            checks++;
            $display("FAIL cmd_accept: cmd_ready stayed 0, required 1 within 5000 cycles");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
    endtask

    // Monitor: protocol checks on req pulses and scoreboard pops on each new response.
    int unsigned   acc_cyc = 0, req_cyc = 0;
    bit            in_rsp = 1'b0, prev_req = 1'b0;
    logic          held_write, held_error;
    logic [DW-1:0] held_rdata;
    cfr_ipif_cmd_t req_e;
    rsp_exp_t      rsp_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_rsp   = 1'b0;
            prev_req = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (wr_req || rd_req) begin
                check("req_one_cycle", 64'(prev_req), 64'd0);
                check("req_exclusive", 64'(wr_req && rd_req), 64'd0);
                check("req_latency", 64'(cyc - acc_cyc), 64'd1);
                req_cyc = cyc;
                if (req_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_req: got req with no command, required none");
                end else begin
                    req_e = req_q.pop_front();
                    check("req_type", 64'(wr_req), 64'(req_e.write));
                    if (req_e.write) begin
                        check("wr_addr", 64'(wr_addr), 64'(req_e.addr));
                        check("wr_data", 64'(wr_data), 64'(req_e.wdata));
                    end else begin
                        check("rd_addr", 64'(rd_addr), 64'(req_e.addr));
                    end
                end
            end
            prev_req = wr_req || rd_req;
            if (rsp_valid || wr_req || rd_req) check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
            if (rsp_valid) begin
                if (!in_rsp) begin
                    if (rsp_q.size() == 0) begin
                        errors++;
                        checks++;
                        $display("FAIL unexpected_rsp: got rsp_valid with no command pending");
                    end else begin
                        rsp_e = rsp_q.pop_front();
                        check("rsp_write", 64'(rsp_write), 64'(rsp_e.write));
                        check("rsp_rdata", 64'(rsp_rdata), 64'(rsp_e.rdata));
                        check("rsp_error", 64'(rsp_error), 64'(rsp_e.error));
                        check("rsp_latency", 64'(cyc - req_cyc), 64'(rsp_e.lat));
                    end
                    held_write = rsp_write;
                    held_rdata = rsp_rdata;
                    held_error = rsp_error;
                end else begin
                    check("rsp_stable", {rsp_write, rsp_rdata, rsp_error},
                          {held_write, held_rdata, held_error});
                end
                in_rsp = !rsp_ready;
            end
        end
    end

    // Responder: performs writes on req, acks after the planned delay, may pulse the wrong ack.
    initial begin : responder
        ack_plan_t     p;
        logic          is_wr;
        logic [AW-1:0] a;
        wr_ack  = 1'b0;
        rd_ack  = 1'b0;
        rd_data = CFR_IPIF_BAD_DATA;
        forever begin
            @(negedge clk);
            if (rst_n && (wr_req || rd_req) && plan_q.size() != 0) begin
                is_wr = wr_req;
                a     = rd_addr;
                if (wr_req) resp_mem[wr_addr] = wr_data;
                p = plan_q.pop_front();
                for (int i = 0; i <= p.dly; i++) begin
                    @(posedge clk);
                    #1;
                    wr_ack  = 1'b0;
                    rd_ack  = 1'b0;
                    rd_data = CFR_IPIF_BAD_DATA;
                    if (!rst_n) break;
                    if (i == p.dly) begin
                        if (is_wr) begin
                            wr_ack = 1'b1;
                        end else begin
                            rd_ack  = 1'b1;
                            rd_data = resp_mem[a];
                        end
                    end else if (i == p.stray_at) begin
                        if (is_wr) rd_ack = 1'b1;
                        else wr_ack = 1'b1;
                    end
                end
                @(posedge clk);
                #1;
                wr_ack  = 1'b0;
                rd_ack  = 1'b0;
                rd_data = CFR_IPIF_BAD_DATA;
            end
        end
    end

    initial begin : rsp_ready_drv
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 2) != 0);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((rsp_q.size() != 0 || in_rsp) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0 || in_rsp) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d responses outstanding, required 0", rsp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin : stimulus
        int dly, stray;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i]  = '0;
            resp_mem[i] = '0;
        end
        ref_mem[0]  = 32'h0000_00A5;
        resp_mem[0] = 32'h0000_00A5;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;

        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_reqs", 64'({wr_req, rd_req}), 64'd0);
        check("reset_addrs", 64'({wr_addr, rd_addr}), 64'd0);
        check("reset_data", {wr_data, rsp_rdata}, 64'd0);
        check("reset_rsp_flags", 64'({rsp_write, rsp_error}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;

        issue(1'b1, 10'd8, 32'd1, 0, -1);
        issue(1'b0, 10'd0, '0, 0, -1);
        issue(1'b0, 10'd8, '0, 1, -1);
        issue(1'b0, 10'd3, '0, 3, 1);
        issue(1'b1, 10'd4, 32'h1234, 2, 0);
        wait_idle();
`ifdef CFR_IPIF_TIMEOUT_EN
        issue(1'b0, 10'd0, '0, int'(TMO) - 1, -1);
        issue(1'b0, 10'd0, '0, int'(TMO), -1);
        issue(1'b0, 10'd8, '0, int'(TMO) + 1, -1);
        wait_idle();
        repeat (4) @(negedge clk);
        check("late_ack_ignored_valid", 64'(rsp_valid), 64'd0);
        check("late_ack_ignored_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
`else
        issue(1'b0, 10'd0, '0, 1000, 200);
        wait_idle();
`endif

        rsp_mode = 2;
        issue(1'b1, 10'd12, 32'hCAFE_0001, 1, -1);
        fork
            begin
                repeat (15) @(negedge clk);
                rsp_mode = 0;
            end
            issue(1'b0, 10'd12, '0, 0, -1);
        join
        wait_idle();

        rsp_mode = 1;
        for (int k = 0; k < 150; k++) begin
            dly   = TMO_EN ? int'($urandom_range(0, TMO + 1)) : int'($urandom_range(0, 12));
            stray = (dly > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, dly - 1)) : -1;
            issue(1'($urandom), AW'($urandom_range(0, 31)), $urandom, dly, stray);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rsp_mode = 0;
        wait_idle();

        issue(1'b0, 10'd5, '0, 60, -1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_reset_valid_ready", 64'({rsp_valid, cmd_ready}), 64'd0);
        check("midop_reset_reqs", 64'({wr_req, rd_req}), 64'd0);
        check("midop_reset_addrs", 64'({wr_addr, rd_addr}), 64'd0);
        check("midop_reset_data", {wr_data, rsp_rdata}, 64'd0);
        rsp_q.delete();
        req_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b1, 10'd9, 32'h0001_FFFF, 0, -1);
        issue(1'b0, 10'd9, '0, 1, -1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cfr_ipif_initiator.md
Name: cfr_ipif_initiator

Overview:
- Initiator (master) side of the CFR IPIF register bus.
- Converts a valid/ready command stream (write or read, address, data) into single-cycle wr_req/rd_req transactions.
- Waits for wr_ack/rd_ack and returns one response per command on a valid/ready response stream.
- Sits between a host/sequencer (e.g. a CPW table loader or AXI-Lite bridge) and cfr_regs-style responders; one transaction outstanding at a time.

Parameters:
- ADDR_WIDTH, 10, IPIF address width.
- DATA_WIDTH, 32, IPIF data width.
- TIMEOUT, 255, maximum cycles to wait for an ack after req; range 1..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_error  out  1  1 = ack timeout
- wr_addr  out  ADDR_WIDTH  IPIF write address
- wr_req  out  1  IPIF write request, one-cycle pulse
- wr_data  out  DATA_WIDTH  IPIF write data
- wr_ack  in  1  IPIF write acknowledge
- rd_addr  out  ADDR_WIDTH  IPIF read address
- rd_req  out  1  IPIF read request, one-cycle pulse
- rd_data  in  DATA_WIDTH  IPIF read data, valid with rd_ack
- rd_ack  in  1  IPIF read acknowledge

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0 (cmd_ready=0, rsp_valid=0, wr_req=0, rd_req=0, addresses/data 0). FSM goes to IDLE.
- FSM states: IDLE, REQ, WAIT, RSP.
- IDLE: cmd_ready=1. On handshake, latch write/addr/wdata and go to REQ.
- REQ: the cycle after acceptance.
  - Write: wr_req=1 for exactly one cycle, with wr_addr/wr_data driven.
  - Read: rd_req=1 for exactly one cycle, with rd_addr driven.
  - Go to WAIT. The req is never held for more than one cycle, because the responder performs an action on every cycle req is high.
- wr_addr/wr_data/rd_addr hold their last value until the next command.
- WAIT:
  - Matching ack (wr_ack for a write, rd_ack for a read): capture rd_data for reads, rsp_error=0, go to RSP.
  - Non-matching ack: ignored.
  - Timeout counter starts at 0 on entry to WAIT. When it reaches TIMEOUT with no ack: rsp_error=1, rsp_rdata=0, go to RSP.
- RSP: rsp_valid=1 and fields stable until rsp_ready, then go to IDLE. cmd_ready=0 in REQ/WAIT/RSP.
- Latency with a 1-cycle-ack responder: command accepted at T, req at T+1, ack at T+2, rsp_valid at T+3. Back-to-back throughput is one command per 4 cycles with rsp_ready held 1.
- Ack outside WAIT (stray or late, after timeout): ignored, no state change.
- Ack in the same cycle the timeout expires: ack wins, rsp_error=0.
- Reset mid-operation: immediate return to IDLE, req deasserted. The pending command is dropped with no response.
- Timeout counter width is $clog2(TIMEOUT+1). It saturates and does not wrap.

Optional Feature:
- Macro CFR_IPIF_TIMEOUT_EN.
- Defined: timeout counter and rsp_error generation as described above.
- Undefined: no counter; WAIT persists until the matching ack; rsp_error is tied to 0. The TIMEOUT parameter remains but is unused.

Decomposition:
- Package cfr_ipif_pkg holds:
  - state enum typedef cfr_ipif_state_t (IDLE, REQ, WAIT, RSP);
  - packed struct cfr_ipif_cmd_t {write, addr, wdata}, parameterised via package constants CFR_IPIF_ADDR_WIDTH=10 and CFR_IPIF_DATA_WIDTH=32;
  - localparam CFR_IPIF_BAD_DATA=32'hDEADBEEF, for benches.
- One natural sub-module: cfr_ipif_timeout (load/run/expired counter), instantiated only under CFR_IPIF_TIMEOUT_EN.

Test Plan:
- Write: cmd write addr=8 wdata=1, responder acks after 1 cycle -> wr_req high exactly one cycle with wr_addr=8, wr_data=1; rsp_valid at T+3, rsp_write=1, rsp_error=0; responder register now reads 1.
- Read: cmd read addr=0 against a responder returning 32'h0000_00A5 -> rd_req one cycle with rd_addr=0; rsp_rdata=32'hA5, rsp_error=0.
- Timeout (macro on, TIMEOUT=4): read with no ack -> rsp_valid after 4 WAIT cycles, rsp_error=1, rsp_rdata=0. Ack injected 2 cycles later -> ignored, FSM stays IDLE.
- Backpressure and stray acks: rsp_ready=0 for 10 cycles -> rsp fields stable, cmd_ready=0 throughout. A second cmd_valid is held pending. wr_ack pulsed during a read's WAIT -> ignored.
- Reset mid-operation: rst_n low during WAIT -> outputs 0 asynchronously; after release, new write addr=9 wdata=17'h1FFFF completes normally.
- Boundary: ack in the same cycle as timeout expiry -> rsp_error=0. Macro off with ack delayed 1000 cycles -> no error, correct rsp.
